// File: rtl/fabric_edge_pkg.sv
// fabric_edge_pkg: shared widths, S1/N1 bit roles and defaults for fabric edge tiles
package fabric_edge_pkg;
  localparam int EDGE_DW   = 16;
  localparam int DEF_DEPTH = 4;
  localparam int EGR_VALID = 0;
  localparam int ING_READY = 1;
  localparam int EGR_READY = 0;
  localparam int ING_VALID = 1;
  localparam int LB_LO     = 2;
  localparam int LB_HI     = 3;
  typedef logic [EDGE_DW-1:0] edge_word_t;
endpackage

// File: rtl/s_term_bridge_fifo.sv
// s_term_bridge_fifo: synchronous valid/ready FIFO with occupancy output
module s_term_bridge_fifo #(
  parameter int DEPTH = 4,
  parameter int DW    = 16,
  parameter int LW    = $clog2(DEPTH+1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_valid,
  output logic          push_ready,
  input  logic [DW-1:0] push_data,
  output logic          pop_valid,
  input  logic          pop_ready,
  output logic [DW-1:0] pop_data,
  output logic [LW-1:0] level
);
  localparam int AW = $clog2(DEPTH);
  logic [DW-1:0] mem [DEPTH];
  logic [AW:0]   wptr, rptr;
  logic [AW-1:0] head;
  logic          push, pop;
  assign level      = LW'(wptr - rptr);
  assign push_ready = level != LW'(DEPTH);
  assign pop_valid  = level != '0;
  assign push       = push_valid & push_ready;
  assign pop        = pop_valid & pop_ready;
  // when empty, look one slot back so the output holds the last popped word
  assign head       = pop_valid ? rptr[AW-1:0] : rptr[AW-1:0] - AW'(1);
  assign pop_data   = mem[head];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      mem  <= '{default: '0};
    end else begin
      if (push) begin
        mem[wptr[AW-1:0]] <= push_data;
        wptr <= wptr + (AW+1)'(1);
      end
      if (pop) rptr <= rptr + (AW+1)'(1);
    end
  end
endmodule

// File: rtl/s_term_stream_bridge.sv
// s_term_stream_bridge: south terminal tile bridging fabric S4/N4 wires to SoC streams
module s_term_stream_bridge
  import fabric_edge_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int LVL_W = $clog2(DEPTH+1)
) (
  input  logic             CLK,
  input  logic             resetn,
  input  logic [3:0]       S1END,
  input  logic [7:0]       S2MID,
  input  logic [7:0]       S2END,
  input  logic [15:0]      S4END,
  output logic [3:0]       N1BEG,
  output logic [7:0]       N2BEG,
  output logic [7:0]       N2BEGb,
  output logic [15:0]      N4BEG,
  output logic             Co0,
  output logic [15:0]      m_data,
  output logic             m_valid,
  input  logic             m_ready,
  input  logic [15:0]      s_data,
  input  logic             s_valid,
  output logic             s_ready,
  output logic [LVL_W-1:0] e_level,
  output logic [LVL_W-1:0] i_level
);
  for (genvar i = 0; i < 8; i++) begin : g_rev
    assign N2BEG[i]  = S2MID[7-i];
    assign N2BEGb[i] = S2END[7-i];
  end
  assign N1BEG[LB_LO] = S1END[LB_HI];
  assign N1BEG[LB_HI] = S1END[LB_LO];
  assign Co0 = 1'b0;
  s_term_bridge_fifo #(.DEPTH(DEPTH), .DW(EDGE_DW), .LW(LVL_W)) u_egress (
    .clk(CLK), .rst_n(resetn),
    .push_valid(S1END[EGR_VALID]), .push_ready(N1BEG[EGR_READY]), .push_data(S4END),
    .pop_valid(m_valid), .pop_ready(m_ready), .pop_data(m_data), .level(e_level)
  );
  s_term_bridge_fifo #(.DEPTH(DEPTH), .DW(EDGE_DW), .LW(LVL_W)) u_ingress (
    .clk(CLK), .rst_n(resetn),
    .push_valid(s_valid), .push_ready(s_ready), .push_data(s_data),
    .pop_valid(N1BEG[ING_VALID]), .pop_ready(S1END[ING_READY]), .pop_data(N4BEG), .level(i_level)
  );
endmodule

// File: tb/tb_s_term_stream_bridge.sv
// tb_s_term_stream_bridge: loopback vector table plus queue scoreboard for both stream directions
module tb_s_term_stream_bridge;
  localparam int DEPTH = 4;
  logic        CLK = 1'b0;
  logic        resetn;
  logic [3:0]  S1END;
  logic [7:0]  S2MID, S2END;
  logic [15:0] S4END;
  logic [3:0]  N1BEG;
  logic [7:0]  N2BEG, N2BEGb;
  logic [15:0] N4BEG;
  logic        Co0;
  logic [15:0] m_data;
  logic        m_valid, m_ready;
  logic [15:0] s_data;
  logic        s_valid, s_ready;
  logic [2:0]  e_level, i_level;
  int checks = 0;
  int errors = 0;
  logic [15:0] eq[$];
  logic [15:0] iq[$];
  typedef struct {
    logic [7:0] mid, endv;
    logic [1:0] hi;
    logic [7:0] exp_n2, exp_n2b;
    logic [1:0] exp_hi;
  } lb_vec_t;
  lb_vec_t tbl[6];

  s_term_stream_bridge dut (
    .CLK(CLK), .resetn(resetn), .S1END(S1END), .S2MID(S2MID), .S2END(S2END), .S4END(S4END),
    .N1BEG(N1BEG), .N2BEG(N2BEG), .N2BEGb(N2BEGb), .N4BEG(N4BEG), .Co0(Co0),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .e_level(e_level), .i_level(i_level)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // evaluate handshakes from the model state, compare, then advance one clock
  task automatic step();
    bit e_push, e_pop, i_push, i_pop;
    #1;
    e_push = S1END[0] && eq.size() < DEPTH;
    e_pop  = m_ready && eq.size() > 0;
    i_push = s_valid && iq.size() < DEPTH;
    i_pop  = S1END[1] && iq.size() > 0;
    check("e_level", 32'(e_level), 32'(eq.size()));
    check("i_level", 32'(i_level), 32'(iq.size()));
    check("m_valid", 32'(m_valid), 32'(eq.size() != 0));
    check("egr_ready", 32'(N1BEG[0]), 32'(eq.size() < DEPTH));
    check("ing_valid", 32'(N1BEG[1]), 32'(iq.size() != 0));
    check("s_ready", 32'(s_ready), 32'(iq.size() < DEPTH));
    check("co0", 32'(Co0), 32'h0);
    if (e_pop) check("m_data", 32'(m_data), 32'(eq.pop_front()));
    if (i_pop) check("n4beg", 32'(N4BEG), 32'(iq.pop_front()));
    if (e_push) eq.push_back(S4END);
    if (i_push) iq.push_back(s_data);
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic drain();
    S1END = 4'b0010; s_valid = 1'b0; m_ready = 1'b1;
    for (int n = 0; n < 2*DEPTH + 2; n++) step();
    m_ready = 1'b0; S1END = 4'b0000;
    #1;
    check("drain_m_valid", 32'(m_valid), 32'h0);
    check("drain_ing_valid", 32'(N1BEG[1]), 32'h0);
  endtask

  initial begin
    tbl[0] = '{8'h01, 8'h80, 2'b01, 8'h80, 8'h01, 2'b10};
    tbl[1] = '{8'hF0, 8'h0F, 2'b10, 8'h0F, 8'hF0, 2'b01};
    tbl[2] = '{8'hA5, 8'h5A, 2'b11, 8'hA5, 8'h5A, 2'b11};
    tbl[3] = '{8'h12, 8'h3C, 2'b00, 8'h48, 8'h3C, 2'b00};
    tbl[4] = '{8'hC1, 8'h06, 2'b01, 8'h83, 8'h60, 2'b10};
    tbl[5] = '{8'h7E, 8'hE0, 2'b10, 8'h7E, 8'h07, 2'b01};
    resetn = 1'b0;
    S1END = 4'($urandom); S2MID = 8'($urandom); S2END = 8'($urandom); S4END = 16'($urandom);
    m_ready = 1'($urandom); s_data = 16'($urandom); s_valid = 1'($urandom);
    repeat (2) @(negedge CLK);
    #1;
    check("rst_egr_ready", 32'(N1BEG[0]), 32'h1);
    check("rst_s_ready", 32'(s_ready), 32'h1);
    check("rst_m_valid", 32'(m_valid), 32'h0);
    check("rst_ing_valid", 32'(N1BEG[1]), 32'h0);
    check("rst_e_level", 32'(e_level), 32'h0);
    check("rst_i_level", 32'(i_level), 32'h0);
    check("rst_m_data", 32'(m_data), 32'h0);
    check("rst_n4beg", 32'(N4BEG), 32'h0);
    S2MID = 8'h80; #1; check("live_n2beg0_hi", 32'(N2BEG[0]), 32'h1);
    S2MID = 8'h7F; #1; check("live_n2beg0_lo", 32'(N2BEG[0]), 32'h0);
    foreach (tbl[k]) begin
      S2MID = tbl[k].mid; S2END = tbl[k].endv; S1END = {tbl[k].hi, 2'b00};
      #1;
      check("lb_n2beg", 32'(N2BEG), 32'(tbl[k].exp_n2));
      check("lb_n2begb", 32'(N2BEGb), 32'(tbl[k].exp_n2b));
      check("lb_n1hi", 32'(N1BEG[3:2]), 32'(tbl[k].exp_hi));
    end
    S1END = 4'b0000; m_ready = 1'b0; s_valid = 1'b0;
    @(negedge CLK);
    resetn = 1'b1;
    @(negedge CLK);
    // two-word egress, then drain with m_ready
    S1END = 4'b0001; S4END = 16'h1234; step();
    S4END = 16'hABCD; step();
    S1END = 4'b0000; #1;
    check("t2_level", 32'(e_level), 32'h2);
    check("t2_valid", 32'(m_valid), 32'h1);
    check("t2_head", 32'(m_data), 32'h1234);
    m_ready = 1'b1; step();
    check("t2_second", 32'(m_data), 32'hABCD);
    step();
    check("t2_empty", 32'(m_valid), 32'h0);
    check("t2_hold", 32'(m_data), 32'hABCD);
    m_ready = 1'b0;
    // fill to full, offer a fifth word that must be refused
    S1END = 4'b0001;
    for (int n = 0; n < DEPTH; n++) begin S4END = 16'h1000 + 16'(n); step(); end
    #1;
    check("t3_full_ready", 32'(N1BEG[0]), 32'h0);
    S4END = 16'hDEAD; step();
    check("t3_level", 32'(e_level), 32'h4);
    drain();
    // ingress full, continuous push and pop
    s_valid = 1'b1;
    for (int n = 0; n < DEPTH; n++) begin s_data = 16'h2000 + 16'(n); step(); end
    #1;
    check("t4_full", 32'(i_level), 32'h4);
    check("t4_s_ready", 32'(s_ready), 32'h0);
    S1END = 4'b0010;
    for (int n = 0; n < 8; n++) begin s_data = 16'h3000 + 16'(n); step(); end
    drain();
    // async reset with three words buffered
    S1END = 4'b0001;
    for (int n = 0; n < 3; n++) begin S4END = 16'h4000 + 16'(n); step(); end
    S1END = 4'b0000; #1;
    check("t5_level", 32'(e_level), 32'h3);
    #1 resetn = 1'b0;
    #1;
    check("t5_async_valid", 32'(m_valid), 32'h0);
    check("t5_async_level", 32'(e_level), 32'h0);
    eq.delete(); iq.delete();
    @(negedge CLK);
    resetn = 1'b1;
    @(negedge CLK);
    S1END = 4'b0001; S4END = 16'h5555; step();
    S1END = 4'b0000; #1;
    check("t5_first", 32'(m_data), 32'h5555);
    check("t5_valid", 32'(m_valid), 32'h1);
    drain();
    // random traffic on both directions
    for (int n = 0; n < 10000; n++) begin
      S1END = {2'($urandom), 1'($urandom), 1'($urandom)};
      S4END = 16'($urandom); s_data = 16'($urandom);
      s_valid = 1'($urandom); m_ready = 1'($urandom);
      step();
    end
    drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
